// File: rtl/divider_pkg.sv
// Shared widths and FSM state encoding for the 8-by-4 sequential divider.
package divider_pkg;

   localparam int DIVIDEND_W = 8;
   localparam int DIVISOR_W  = 4;
   localparam int REM_W      = 5;
   localparam int CNT_W      = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, then conditionally subtract.
module div_step
   import divider_pkg::*;
(
   input  logic [REM_W-1:0]     partial_rem,
   input  logic                 next_bit,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [REM_W-1:0]     next_rem,
   output logic                 q_bit
);

   logic [REM_W-1:0] trial;

   // The partial remainder is always below the divisor, so its top bit only
   // matters as a safety term; it still forces a subtract if ever set.
   assign trial    = {partial_rem[REM_W-2:0], next_bit};
   assign q_bit    = partial_rem[REM_W-1] | (trial >= {1'b0, divisor});
   assign next_rem = q_bit ? (trial - {1'b0, divisor}) : trial;

endmodule

// File: rtl/divider_8by4_seq.sv
// 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock, MSB first.
module divider_8by4_seq
   import divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   state_t                state, next_state;
   logic                  accept;
   logic [CNT_W-1:0]      cnt;
   logic [REM_W-1:0]      part_rem;
   logic [DIVIDEND_W-1:0] work;
   logic [DIVISOR_W-1:0]  dvs;
   logic [REM_W-1:0]      step_rem;
   logic                  step_q;

   div_step u_step (
      .partial_rem (part_rem),
      .next_bit    (work[DIVIDEND_W-1]),
      .divisor     (dvs),
      .next_rem    (step_rem),
      .q_bit       (step_q)
   );

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: defaults come first so no path leaves a signal unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = (divisor == '0) ? DONE : CALC;
            end else begin
               next_state = IDLE;
            end
         end
         CALC:    if (cnt == '0) next_state = DONE;
         default: next_state = IDLE;
      endcase
   end

   // Dividend bits shift out of work's MSB while quotient bits shift into its LSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         part_rem    <= '0;
         work        <= '0;
         dvs         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         cnt      <= CNT_W'(7);
         part_rem <= '0;
         work     <= dividend;
         dvs      <= divisor;
         if (divisor == '0) begin
            quotient    <= 8'hFF;
            remainder   <= 4'hF;
            div_by_zero <= 1'b1;
         end
      end else if (state == CALC) begin
         cnt      <= cnt - 3'd1;
         part_rem <= step_rem;
         work     <= {work[DIVIDEND_W-2:0], step_q};
         if (cnt == '0) begin
            quotient    <= {work[DIVIDEND_W-2:0], step_q};
            remainder   <= step_rem[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
         end
      end
   end

   assign busy = (state == CALC);
   assign done = (state == DONE);

endmodule

// File: tb/tb_divider_8by4_seq.sv
// Directed and exhaustive checks of divider_8by4_seq against hand-computed and / % results.
module tb_divider_8by4_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy, done, div_by_zero;
   logic [7:0] quotient;
   logic [3:0] remainder;

   int n_tests = 0;
   int n_fail  = 0;

   divider_8by4_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drives one start pulse and waits (bounded) for done; lat counts edges
   // including the accepting one, nbusy counts sampled busy cycles.
   task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                         output int lat, output int nbusy);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      nbusy = 0;
      while (!done && lat < 20) begin
         if (busy) nbusy++;
         check("busy_done_excl", 32'(busy & done), 32'd0);
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, nbusy, ndone, first_edge, gap, edge_no;
      logic [7:0] exp_q;
      logic [3:0] exp_r;
      logic       exp_z;

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_q",    32'(quotient), 32'd0);
      check("rst_r",    32'(remainder), 32'd0);
      check("rst_dbz",  32'(div_by_zero), 32'd0);
      rst = 1'b0;

      // 200 / 7
      do_div(8'd200, 4'd7, lat, nbusy);
      check("d200_lat",   32'(lat), 32'd9);
      check("d200_busy",  32'(nbusy), 32'd8);
      check("d200_q",     32'(quotient), 32'd28);
      check("d200_r",     32'(remainder), 32'd4);
      check("d200_dbz",   32'(div_by_zero), 32'd0);
      @(negedge clk);
      check("d200_pulse", 32'(done), 32'd0);
      check("d200_hold",  32'(quotient), 32'd28);

      // 5 / 0
      do_div(8'd5, 4'd0, lat, nbusy);
      check("dz_lat",  32'(lat), 32'd1);
      check("dz_busy", 32'(nbusy), 32'd0);
      check("dz_q",    32'(quotient), 32'hFF);
      check("dz_r",    32'(remainder), 32'hF);
      check("dz_dbz",  32'(div_by_zero), 32'd1);
      @(negedge clk);
      check("dz_hold", 32'(div_by_zero), 32'd1);

      // 255 / 15 with an ignored 9 / 2 start during CALC
      @(negedge clk);
      dividend = 8'd255; divisor = 4'd15; start = 1'b1;
      @(negedge clk);
      dividend = 8'd9; divisor = 4'd2;
      repeat (3) @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 14; i++) begin
         if (done) begin
            ndone++;
            check("ign_q", 32'(quotient), 32'd17);
            check("ign_r", 32'(remainder), 32'd0);
         end
         @(negedge clk);
      end
      check("ign_ndone", 32'(ndone), 32'd1);

      // reset four cycles into CALC
      dividend = 8'd200; divisor = 4'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy",  32'(busy), 32'd0);
      check("abort_done",  32'(done), 32'd0);
      check("abort_q",     32'(quotient), 32'd0);
      check("abort_r",     32'(remainder), 32'd0);
      check("abort_dbz",   32'(div_by_zero), 32'd0);
      check("abort_state", 32'(dut.state), 32'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("abort_nodone", 32'(ndone), 32'd0);
      do_div(8'd12, 4'd5, lat, nbusy);
      check("d12_q", 32'(quotient), 32'd2);
      check("d12_r", 32'(remainder), 32'd2);

      // back-to-back: 100 / 3 then 255 / 1 with start held high
      @(negedge clk);
      dividend = 8'd100; divisor = 4'd3; start = 1'b1;
      @(negedge clk);
      dividend = 8'd255; divisor = 4'd1;
      ndone = 0; first_edge = 0; gap = 0; edge_no = 1;
      while (ndone < 2 && edge_no < 40) begin
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               first_edge = edge_no;
               check("b2b_q1", 32'(quotient), 32'd33);
               check("b2b_r1", 32'(remainder), 32'd1);
            end else begin
               gap   = edge_no - first_edge;
               start = 1'b0;
               check("b2b_q2", 32'(quotient), 32'd255);
               check("b2b_r2", 32'(remainder), 32'd0);
            end
         end
         @(negedge clk);
         edge_no++;
      end
      start = 1'b0;
      check("b2b_first", 32'(first_edge), 32'd9);
      check("b2b_gap",   32'(gap), 32'd9);

      // exhaustive sweep
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            do_div(8'(a), 4'(b), lat, nbusy);
            if (b == 0) begin
               exp_q = 8'hFF; exp_r = 4'hF; exp_z = 1'b1;
            end else begin
               exp_q = 8'(a / b); exp_r = 4'(a % b); exp_z = 1'b0;
            end
            check("sweep_lat", 32'(lat), (b == 0) ? 32'd1 : 32'd9);
            check("sweep_res", {19'd0, quotient, remainder, div_by_zero},
                               {19'd0, exp_q, exp_r, exp_z});
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
